// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and counter widths shared by the loader and its byte assembler.
package imem_loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;
    localparam int BCNT_W = 2;
    function automatic int idx_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: packs four accepted bytes little-endian into a word and pulses word_valid_o on the fourth.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);
    logic [23:0]       sr_q;
    logic [BCNT_W-1:0] cnt_q;
    // The fourth byte is forwarded combinationally so the word is usable on the same edge it completes.
    assign word_o       = {data_i, sr_q};
    assign word_valid_o = en_i && (&cnt_q);
    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (en_i) begin
            sr_q  <= {data_i, sr_q[23:8]};
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader that reads a word-count header then that many little-endian words from a
// byte stream, writing each to instruction memory at consecutive word addresses.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      wr_addr0,
    output logic [WIDTH-1:0] wr_din0,
    output logic             we0,
    output logic             busy,
    output logic             done,
    output logic             error
);
    localparam int IDX_W = idx_w(DEPTH);
    state_t           state_q;
    logic [IDX_W-1:0] idx_q, n_q, idx_nx;
    logic [31:0]      wr_addr0_q, word;
    logic [WIDTH-1:0] wr_din0_q;
    logic             accept, launch, word_valid;

    assign in_ready = state_q == HDR || state_q == DATA;
    assign busy     = in_ready || state_q == WRITE;
    assign we0      = state_q == WRITE;
    assign done     = state_q == DONE;
    assign error    = state_q == ERR;
    assign wr_addr0 = wr_addr0_q;
    assign wr_din0  = wr_din0_q;
    assign accept   = in_valid && in_ready;
    assign launch   = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign idx_nx   = idx_q + 1'b1;

    byte_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (launch),
        .en_i        (accept),
        .data_i      (in_data),
        .word_o      (word),
        .word_valid_o(word_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            wr_addr0_q <= '0;
            wr_din0_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: if (launch) begin
                    state_q <= HDR;
                    idx_q   <= '0;
                end
                HDR: if (word_valid) begin
                    // Full 32-bit compare so huge counts cannot alias into the legal range.
                    state_q <= word > 32'(DEPTH) ? ERR : word == '0 ? DONE : DATA;
                    n_q     <= word[IDX_W-1:0];
                end
                DATA: if (word_valid) begin
                    state_q    <= WRITE;
                    wr_din0_q  <= word;
                    wr_addr0_q <= 32'({idx_q, 2'b00});
                end
                WRITE: begin
                    idx_q   <= idx_nx;
                    state_q <= idx_nx == n_q ? DONE : DATA;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized sessions checked against a list-based model of the expected memory image.
module tb_imem_loader;
    localparam int DEPTH = 128;
    logic        clk = 0, rst = 0, start = 0, in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, we0, busy, done, error;
    logic [31:0] wr_addr0, wr_din0;
    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] wq_addr[$], wq_data[$], src[$];
    int          checks = 0, errors = 0;

    imem_loader #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_addr0(wr_addr0), .wr_din0(wr_din0), .we0(we0),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Instruction memory stand-in with a log of every write strobe.
    always @(posedge clk) if (we0) begin
        wq_addr.push_back(wr_addr0);
        wq_data.push_back(wr_din0);
        mem[wr_addr0[8:2]] <= wr_din0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap == 0 ? 0 : $urandom_range(gap, 0)) @(negedge clk);
        in_data  = b;
        in_valid = 1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", {31'b0, in_ready}, 1);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input int nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic begin_session(input logic [31:0] n, input int gap);
        wq_addr.delete();
        wq_data.delete();
        pulse_start();
        chk("busy_hdr", {31'b0, busy}, 1);
        chk("done_clr", {31'b0, done}, 0);
        chk("err_clr", {31'b0, error}, 0);
        send_word(n, gap, 4);
    endtask

    // Model: a legal count yields words 0..n-1 at byte addresses 4*i then done; an oversized one yields error only.
    task automatic verify(input logic [31:0] n);
        int t = 0;
        logic legal;
        legal = n <= DEPTH;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("busy_end", {31'b0, busy}, 0);
        chk("done", {31'b0, done}, {31'b0, legal});
        chk("error", {31'b0, error}, {31'b0, !legal});
        chk("ready_end", {31'b0, in_ready}, 0);
        chk("we_end", {31'b0, we0}, 0);
        chk("n_writes", wq_addr.size(), legal ? n : 0);
        if (legal && wq_addr.size() == n)
            for (int i = 0; i < n; i++) begin
                chk("wr_addr", wq_addr[i], 4 * i);
                chk("wr_data", wq_data[i], src[i]);
            end
    endtask

    task automatic session(input logic [31:0] n, input int gap);
        begin_session(n, gap);
        if (n <= DEPTH) for (int i = 0; i < n; i++) send_word(src[i], gap, 4);
        verify(n);
    endtask

    task automatic rand_src(input int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back($urandom);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, in_ready}, 0);
        chk("rst_we", {31'b0, we0}, 0);
        chk("rst_addr", wr_addr0, 0);
        chk("rst_din", wr_din0, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, error}, 0);
        rst = 1;
        @(negedge clk);

        src = '{32'h0000_0013, 32'h0010_0093};
        session(2, 0);

        src.delete();
        session(0, 2);

        session(129, 1);
        session(32'h0001_0002, 0);

        rand_src(DEPTH);
        session(DEPTH, 3);
        chk("last_addr", wq_addr.size() > 0 ? wq_addr[wq_addr.size()-1] : 32'hx, 32'h1FC);
        for (int i = 0; i < DEPTH; i++) chk("readback", mem[i], src[i]);

        rand_src(5);
        begin_session(5, 1);
        send_word(src[0], 1, 4);
        send_word(src[1], 1, 4);
        send_word(src[2], 1, 2);
        rst = 0;
        @(negedge clk);
        rst = 1;
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_ready", {31'b0, in_ready}, 0);
        chk("mid_rst_done", {31'b0, done}, 0);
        chk("mid_rst_addr", wr_addr0, 0);
        repeat (5) @(negedge clk);
        chk("mid_rst_writes", wq_addr.size(), 2);
        rand_src(4);
        session(4, 2);

        rand_src(3);
        begin_session(3, 0);
        send_word(src[0], 0, 4);
        send_word(src[1], 0, 2);
        pulse_start();
        chk("start_ignored", {31'b0, busy}, 1);
        send_word(src[1] >> 16, 0, 2);
        send_word(src[2], 0, 4);
        verify(3);

        rand_src(7);
        session(7, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
